keypad_scanner: RTL

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_scanner.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a 4x4 active-low matrix keypad one row at a time, debounces a
//   single key press, and holds its code until the key is fully released.
//
//   Parameters
//     SCAN_DIV   : clk cycles each row is driven before moving on (>= 4)
//     DEB_CYCLES : consecutive stable cycles needed to accept a press or
//                  a release (>= 2)
//
//   Ports
//     clk       : system clock, all state changes on its rising edge
//     RESET     : asynchronous active-high reset
//     COL[3:0]  : column sense lines, active-low, asynchronous to clk
//     ROW[3:0]  : row drive, active-low, exactly one bit low at all times
//     decode    : held key code, 0 = no key, 1..15 = accepted key
//     KEY_VALID : one-cycle pulse when decode goes from 0 to a key code
//
//   Configuration
//     KEYPAD_DEBOUNCE_EN defined   : full DEB_CYCLES debounce on press and
//                                    release.
//     KEYPAD_DEBOUNCE_EN undefined : DEB_CYCLES is ignored, press and
//                                    release each settle after a single
//                                    stable cycle (fast simulation).

module keypad_scanner #(
  parameter int SCAN_DIV   = 1000,
  parameter int DEB_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic [3:0] COL,
  output logic [3:0] ROW,
  output logic [3:0] decode,
  output logic       KEY_VALID
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int DEB_W = $clog2(DEB_CYCLES);

`ifdef KEYPAD_DEBOUNCE_EN
  localparam int DEB_TARGET = DEB_CYCLES;
`else
  localparam int DEB_TARGET = 1;
`endif

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_TARGET - 1);

  localparam logic [1:0] ST_SCAN     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_HELD     = 2'd2;
  localparam logic [1:0] ST_RELEASE  = 2'd3;

  logic [1:0]       state;
  logic [1:0]       row_sel;
  logic [DIV_W-1:0] div_cnt;
  logic [DEB_W-1:0] deb_cnt;
  logic [3:0]       cap_idx;
  logic [3:0]       col_s1;
  logic [3:0]       col_s2;

  logic [3:0]       col_sync;
  logic [1:0]       col_idx;
  logic             col_single;
  logic [3:0]       cand_idx;
  logic             cand_ok;
  logic [3:0]       cap_pat;
  logic             all_high;

  // Two-flop synchronizer for the keypad columns. Idle level is all ones,
  // so reset loads ones to avoid a phantom press right after reset.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      col_s1 <= 4'b1111;
      col_s2 <= 4'b1111;
    end else begin
      col_s1 <= COL;
      col_s2 <= col_s1;
    end
  end

  assign col_sync = col_s2;
  assign all_high = (col_sync == 4'b1111);

  // Only patterns with exactly one low column map to a key; anything with
  // two or more low columns is treated as no key at all.
  always_comb begin
    col_idx    = 2'd0;
    col_single = 1'b0;
    case (col_sync)
      4'b1110: begin col_idx = 2'd0; col_single = 1'b1; end
      4'b1101: begin col_idx = 2'd1; col_single = 1'b1; end
      4'b1011: begin col_idx = 2'd2; col_single = 1'b1; end
      4'b0111: begin col_idx = 2'd3; col_single = 1'b1; end
      default: begin col_idx = 2'd0; col_single = 1'b0; end
    endcase
  end

  // Key index 15 has no code in the 4-bit decode space, so it is rejected.
  assign cand_idx = {row_sel, col_idx};
  assign cand_ok  = col_single && (cand_idx != 4'hF);

  // The column pattern a captured key produces while its row is driven.
  assign cap_pat  = ~(4'b0001 << cap_idx[1:0]);

  assign ROW = ~(4'b0001 << row_sel);

  // Main scan / debounce / hold / release state machine. KEY_VALID defaults
  // low every cycle and is raised only on the DEBOUNCE to HELD transition,
  // which can never occur twice in a row.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state     <= ST_SCAN;
      row_sel   <= 2'd0;
      div_cnt   <= '0;
      deb_cnt   <= '0;
      cap_idx   <= 4'd0;
      decode    <= 4'd0;
      KEY_VALID <= 1'b0;
    end else begin
      KEY_VALID <= 1'b0;
      case (state)
        ST_SCAN: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (cand_ok) begin
              cap_idx <= cand_idx;
              deb_cnt <= '0;
              state   <= ST_DEBOUNCE;
            end else begin
              row_sel <= row_sel + 2'd1;
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        ST_DEBOUNCE: begin
          if (col_sync == cap_pat) begin
            if (deb_cnt == DEB_LAST) begin
              deb_cnt   <= '0;
              decode    <= cap_idx + 4'd1;
              KEY_VALID <= 1'b1;
              state     <= ST_HELD;
            end else if (deb_cnt != '1) begin
              deb_cnt <= deb_cnt + DEB_W'(1);
            end
          end else begin
            deb_cnt <= '0;
            div_cnt <= '0;
            row_sel <= row_sel + 2'd1;
            state   <= ST_SCAN;
          end
        end

        ST_HELD: begin
          if (all_high) begin
            deb_cnt <= '0;
            state   <= ST_RELEASE;
          end
        end

        ST_RELEASE: begin
          if (all_high) begin
            if (deb_cnt == DEB_LAST) begin
              deb_cnt <= '0;
              decode  <= 4'd0;
              row_sel <= 2'd0;
              div_cnt <= '0;
              state   <= ST_SCAN;
            end else if (deb_cnt != '1) begin
              deb_cnt <= deb_cnt + DEB_W'(1);
            end
          end else begin
            deb_cnt <= '0;
            state   <= ST_HELD;
          end
        end

        default: begin
          state <= ST_SCAN;
        end
      endcase
    end
  end

endmodule
